free_list_ctrl: RTL

Physical-register free-list controller for the rename stage. Holds the tags of free physical registers in a circular FIFO, grants one new destination tag per cycle to rename, and takes back one tag per cycle released at commit. Keeps a speculative and an architectural read pointer, so that a pipeline flush returns every uncommitted allocation to the pool in a single cycle. It replaces the bit-vector free pool and priority encoder in the rename stage.

---
 rtl/free_list_ctrl_if.sv | 31 +++
 rtl/free_list_ctrl.sv | 80 ++++++++
 2 files changed

// File: rtl/free_list_ctrl_if.sv
// Rename/commit-side bus of the physical-register free list.
// master = rename/commit logic, slave = free_list_ctrl.
interface free_list_ctrl_if #(
  parameter int TAG_W = 6
);
  logic             alloc_req;
  logic             alloc_gnt;
  logic [TAG_W-1:0] alloc_prd;
  logic             stall_out;
  logic             free_valid;
  logic [TAG_W-1:0] free_prd;
  logic             commit_alloc;
  logic             flush;
  logic             empty;
  logic [TAG_W-1:0] free_count;
  logic             err;

  modport master (
    output alloc_req, free_valid, free_prd,
    output commit_alloc, flush,
    input  alloc_gnt, alloc_prd, stall_out,
    input  empty, free_count, err
  );

  modport slave (
    input  alloc_req, free_valid, free_prd,
    input  commit_alloc, flush,
    output alloc_gnt, alloc_prd, stall_out,
    output empty, free_count, err
  );
endinterface

// File: rtl/free_list_ctrl.sv
// Circular free list of physical tags with speculative and
// architectural heads for single-cycle flush recovery.
module free_list_ctrl #(
  parameter int NUM_REG   = 32,
  parameter int NUM_P_REG = 64,
  parameter int DEPTH     = NUM_P_REG - NUM_REG,
  parameter int TAG_W     = $clog2(NUM_P_REG)
) (
  input  logic clk,
  input  logic rst,
  free_list_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [TAG_W-1:0] mem [DEPTH];
  logic [PW-1:0]    spec_head;
  logic [PW-1:0]    arch_head;
  logic [PW-1:0]    tail;
  logic [PW-1:0]    spec_cnt;
  logic [PW-1:0]    arch_cnt;
  logic [PW-1:0]    arch_nxt;
  logic             empty;
  logic             gnt;
  logic             rel_try;
  logic             rel_ok;
  logic             rel_err;
  logic             cmt_ok;
  logic             cmt_err;
  logic             err_q;

  assign spec_cnt = tail - spec_head;
  assign arch_cnt = tail - arch_head;
  assign empty    = (spec_cnt == '0);
  assign gnt      = bus.alloc_req & ~empty
                  & ~bus.flush;

  assign bus.empty      = empty;
  assign bus.alloc_gnt  = gnt;
  assign bus.stall_out  = bus.alloc_req & ~gnt;
  assign bus.free_count = TAG_W'(spec_cnt);
  assign bus.alloc_prd  = mem[spec_head[AW-1:0]];
  assign bus.err        = err_q;

  // p0 is hard-wired x0 and never enters the pool
  assign rel_try = bus.free_valid
                 & (bus.free_prd != '0);
  assign rel_ok  = rel_try
                 & (arch_cnt < PW'(DEPTH));
  assign rel_err = rel_try & ~rel_ok;

  assign cmt_ok  = bus.commit_alloc
                 & (arch_head != spec_head);
  assign cmt_err = bus.commit_alloc & ~cmt_ok;
  assign arch_nxt = cmt_ok ? arch_head + PW'(1)
                           : arch_head;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= TAG_W'(NUM_REG + i);
      spec_head <= '0;
      arch_head <= '0;
      tail      <= PW'(DEPTH);
      err_q     <= 1'b0;
    end else begin
      if (rel_ok) begin
        mem[tail[AW-1:0]] <= bus.free_prd;
        tail <= tail + PW'(1);
      end
      arch_head <= arch_nxt;
      if (bus.flush)
        spec_head <= arch_nxt;
      else if (gnt)
        spec_head <= spec_head + PW'(1);
      if (rel_err | cmt_err)
        err_q <= 1'b1;
    end
  end
endmodule
